fft_peak_detect: RTL
====================

Name: fft_peak_detect

Overview:
Streaming post-processor placed directly downstream of FFT_top. It consumes the FFT output bin stream (16-bit signed re/im, one bin per accepted cycle) and computes squared magnitude per bin. It finds the largest bin within a configurable index window and reports that bin's index and magnitude once per N-bin frame. Its output feeds the readout/register logic for tone detection.

Parameters:
N, 1024, bins per frame (power of two)
BIN_LO, 1, lowest bin index included in the search (inclusive)
BIN_HI, 511, highest bin index included in the search (inclusive); requires BIN_LO <= BIN_HI <= N-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  current in_re/in_im is a valid FFT bin
frame_sync  in  1  qualified by in_valid; marks the current sample as bin 0
in_re  in  16  signed real part of the bin (from FFT_top Xb_re)
in_im  in  16  signed imaginary part of the bin (from FFT_top Xb_im)
peak_valid  out  1  one-cycle pulse: peak result for the completed frame
peak_bin  out  log2(N)  index of the maximum bin
peak_mag  out  32  unsigned re^2+im^2 of the maximum bin

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: peak_valid=0, peak_bin=0, peak_mag=0. The bin counter, pipeline valids, running max and frame_ok flag all clear to 0.
- Bin counter:
  - Advances only on in_valid; values are 0..N-1, wrapping N-1 -> 0.
  - A sample with in_valid=1 and frame_sync=1 is bin 0, whatever the counter value.
  - frame_sync without in_valid is ignored.
- Frame completeness:
  - After reset the first frame starts at counter 0, so frame_ok=1.
  - frame_sync while the counter is not 0 abandons the partial frame: no peak_valid for it, running max cleared, frame_ok stays 1 for the new frame.
- Magnitude pipeline, sub-module fft_magsq, 2 stages, valid/bin index travel alongside:
  - S1 registers re*re and im*im (signed 16x16, each result 0..2^30).
  - S2 registers the 32-bit unsigned sum. The maximum is 2^31 at (-32768,-32768), so no overflow.
- Compare stage S3, on a valid S2 result whose bin is in [BIN_LO, BIN_HI]:
  - If this is the first in-window bin of the frame, or mag > max_mag (strict), load max_mag/max_bin.
  - Ties keep the lower index.
  - Bins outside the window never update the max.
- Result:
  - When the S3 item is bin N-1 of a complete frame, register peak_bin/peak_mag from the final max (including that item) and pulse peak_valid for 1 cycle.
  - Latency: the sample with bin N-1 accepted at edge t gives peak_valid=1 in the cycle after edge t+3.
  - The running max then resets for the next frame.
  - peak_bin/peak_mag hold until the next result.
- Input gaps: in_valid=0 cycles insert bubbles. Latency is counted from the last valid sample's acceptance, with the pipeline advancing every cycle. The result does not depend on gaps.
- Back-to-back frames (no gap between bin N-1 and the next bin 0) are supported at full rate with no lost samples.
- Reset mid-frame: everything is discarded and no peak_valid is produced for that frame.
- No backpressure: the block always accepts data.

Decomposition:
- Package fft_pkg:
  - N_FFT=1024
  - SAMPLE_W=16
  - BIN_W=$clog2(N_FFT)
  - MAG_W=32
  - default BIN_LO/BIN_HI
- Sub-module fft_magsq: 2-stage squared-magnitude pipeline with a pass-through valid and a BIN_W tag.

Test Plan:
1. Assert rst for 5 cycles mid-stream -> all outputs 0; the next frame starts at bin 0; no stale peak_valid.
2. One frame all zeros except bin 10 = (1000, -500) -> peak_bin=10, peak_mag=1250000, peak_valid exactly 3 cycles after bin 1023 is accepted (in the cycle after edge t+3).
3. Bins 20 and 30 both = (300, 400) -> peak_bin=20, peak_mag=250000.
4. Bin 0 = (32767, 0), bin 600 = (20000, 0), all others 0, defaults -> out of window; peak_bin=1 (first in-window), peak_mag=0.
5. Bin 100 = (-32768, -32768) -> peak_mag=2147483648, peak_bin=100. Repeat with in_valid toggled every other cycle -> identical result, one pulse.
6. frame_sync at counter 300, then a full frame with peak at bin 7 = (10, 10) -> no pulse for the aborted frame; a single pulse with peak_bin=7, peak_mag=200.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared widths and default search window for the FFT peak-detect post-processor.
package fft_pkg;

  localparam int unsigned N_FFT      = 1024;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned BIN_W      = $clog2(N_FFT);
  localparam int unsigned MAG_W      = 32;
  localparam int unsigned BIN_LO_DEF = 1;
  localparam int unsigned BIN_HI_DEF = 511;

  typedef logic [MAG_W-1:0] mag_t;

endpackage

// File: rtl/fft_magsq.sv
// Two-stage squared-magnitude pipeline; valid and a tag travel alongside the data.
module fft_magsq
  import fft_pkg::*;
#(
  parameter int unsigned TAG_W = BIN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic signed [SAMPLE_W-1:0] in_re,
  input  logic signed [SAMPLE_W-1:0] in_im,
  output logic                       out_valid,
  output logic [TAG_W-1:0]           out_tag,
  output mag_t                       out_mag
);

  logic signed [2*SAMPLE_W-1:0] prod_re;
  logic signed [2*SAMPLE_W-1:0] prod_im;
  mag_t                         sq_re;
  mag_t                         sq_im;
  logic                         v1;
  logic [TAG_W-1:0]             tag1;

  // Signed 16x16 squares; each result is 0..2^30 so the unsigned view is exact.
  always_comb begin
    prod_re = in_re * in_re;
    prod_im = in_im * in_im;
  end

  // Valid flags are the only pipeline state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
    end
  end

  // Data path: S1 squares, S2 sum (max 2^31, fits MAG_W unsigned).
  always_ff @(posedge clk) begin
    sq_re   <= MAG_W'($unsigned(prod_re));
    sq_im   <= MAG_W'($unsigned(prod_im));
    tag1    <= in_tag;
    out_mag <= sq_re + sq_im;
    out_tag <= tag1;
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over a bin window of the FFT output stream.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int unsigned N      = N_FFT,
  parameter int unsigned BIN_LO = BIN_LO_DEF,
  parameter int unsigned BIN_HI = BIN_HI_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       frame_sync,
  input  logic signed [SAMPLE_W-1:0] in_re,
  input  logic signed [SAMPLE_W-1:0] in_im,
  output logic                       peak_valid,
  output logic [$clog2(N)-1:0]       peak_bin,
  output logic [MAG_W-1:0]           peak_mag
);

  localparam int unsigned BW    = $clog2(N);
  localparam int unsigned TAG_W = BW + 1;

  logic [BW-1:0]    cnt;
  logic [BW-1:0]    idx;
  logic             frame_ok;
  logic [TAG_W-1:0] tag_in;

  logic             v2;
  logic [TAG_W-1:0] tag2;
  mag_t             mag2;
  logic [BW-1:0]    bin2;
  logic             ok2;

  logic             have_max;
  mag_t             max_mag;
  logic [BW-1:0]    max_bin;
  logic             base_have;
  mag_t             base_mag;
  logic [BW-1:0]    base_bin;
  logic             in_win;
  logic             upd;
  logic             last;
  logic             nxt_have;
  mag_t             nxt_mag;
  logic [BW-1:0]    nxt_bin;

  logic             done;
  mag_t             res_mag;
  logic [BW-1:0]    res_bin;

  // A qualified frame_sync forces bin 0 regardless of the counter.
  always_comb begin
    idx    = (in_valid && frame_sync) ? '0 : cnt;
    tag_in = {frame_ok | (idx == '0), idx};
  end

  // Bin counter wraps naturally at N (power of two); frame_ok marks a frame seen from bin 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      frame_ok <= 1'b0;
    end else if (in_valid) begin
      cnt <= idx + BW'(1);
      if (idx == '0) frame_ok <= 1'b1;
    end
  end

  fft_magsq #(.TAG_W(TAG_W)) u_magsq (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_tag    (tag_in),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (v2),
    .out_tag   (tag2),
    .out_mag   (mag2)
  );

  // Compare: bin 0 starts a fresh search (also abandons any partial frame); ties keep the lower bin.
  always_comb begin
    ok2       = tag2[BW];
    bin2      = tag2[BW-1:0];
    base_have = have_max;
    base_mag  = max_mag;
    base_bin  = max_bin;
    if (v2 && (bin2 == '0)) begin
      base_have = 1'b0;
      base_mag  = '0;
      base_bin  = '0;
    end
    in_win   = (bin2 >= BW'(BIN_LO)) && (bin2 <= BW'(BIN_HI));
    upd      = v2 && in_win && (!base_have || (mag2 > base_mag));
    nxt_have = base_have | upd;
    nxt_mag  = upd ? mag2 : base_mag;
    nxt_bin  = upd ? bin2 : base_bin;
    last     = v2 && (bin2 == BW'(N - 1));
  end

  // Running max; on the final bin capture the result and clear for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_max <= 1'b0;
      max_mag  <= '0;
      max_bin  <= '0;
      done     <= 1'b0;
      res_mag  <= '0;
      res_bin  <= '0;
    end else begin
      done <= last && ok2;
      if (last) begin
        res_mag  <= nxt_mag;
        res_bin  <= nxt_bin;
        have_max <= 1'b0;
        max_mag  <= '0;
        max_bin  <= '0;
      end else if (v2) begin
        have_max <= nxt_have;
        max_mag  <= nxt_mag;
        max_bin  <= nxt_bin;
      end
    end
  end

  // Result registers hold until the next completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
    end else begin
      peak_valid <= done;
      if (done) begin
        peak_bin <= res_bin;
        peak_mag <= res_mag;
      end
    end
  end

endmodule
